shape_select_ctrl: RTL
======================

SHAPE_SELECT_CTRL -- requirements
Module: shape_select_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per 1 ms debounce tick.
REQ-002 Parameter DEBOUNCE_MS, default 200, ticks of stable input needed to accept a press or release; legal range 1..1023.
REQ-003 Parameter NUM_SEL, default 7, number of selection values (0..NUM_SEL-1); legal range 2..8.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btnU  input  1  raw push-button, asynchronous to clk, may bounce.
REQ-007 clear  input  1  synchronous request to force sel to 0.
REQ-008 sel  output  3  current selection index, consumed by the pixel-colour stage as its shape/colour select.
REQ-009 press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-010 btn_level  output  1  debounced button level.

Function
REQ-011 btnU SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (btn_s).
REQ-012 A free-running prescaler SHALL assert internal tick for one clk every TICK_DIV cycles (counts 0..TICK_DIV-1, tick at TICK_DIV-1, then wraps to 0).
REQ-013 FSM states SHALL be IDLE, PRESS_WAIT, HELD and REL_WAIT, with a stability counter ms_cnt of 10 bits.
- IDLE: btn_s=1 -> PRESS_WAIT, ms_cnt<=0.
- PRESS_WAIT: btn_s=0 -> IDLE; else on tick ms_cnt+1; when ms_cnt+1 = DEBOUNCE_MS on a tick -> HELD.
- HELD: btn_s=0 -> REL_WAIT, ms_cnt<=0.
- REL_WAIT: btn_s=1 -> HELD (no new press); else on tick ms_cnt+1; when ms_cnt+1 = DEBOUNCE_MS on a tick -> IDLE.
REQ-014 btn_level SHALL be 1 in HELD and REL_WAIT and 0 in IDLE and PRESS_WAIT.
REQ-015 On the PRESS_WAIT->HELD transition, press_pulse SHALL be 1 for exactly the following clk cycle, and sel SHALL advance by 1 on the same edge as press_pulse rises.
REQ-016 sel SHALL wrap from NUM_SEL-1 to 0; sel SHALL never hold a value >= NUM_SEL.
REQ-017 Holding the button SHALL produce exactly one press; auto-repeat is not provided.
REQ-018 Release bounce shorter than DEBOUNCE_MS ticks SHALL NOT produce a press.
REQ-019 clear=1 SHALL set sel to 0 on the next edge, and clear SHALL take priority over a simultaneous advance; press_pulse still fires in that case; FSM unaffected.
REQ-020 Press acceptance latency from btnU rise (stable) SHALL be 2 sync cycles + between (DEBOUNCE_MS-1)*TICK_DIV+1 and DEBOUNCE_MS*TICK_DIV cycles, + 1 output cycle.
REQ-021 Any btn_s glitch in PRESS_WAIT SHALL restart debounce from IDLE, and the accumulated ms_cnt SHALL be discarded.

Reset
REQ-022 reset=1 SHALL asynchronously force FSM=IDLE, ms_cnt=0, prescaler=0, synchronizer flops=0, sel=0, press_pulse=0, btn_level=0.
REQ-023 Reset asserted mid-debounce or while HELD SHALL lose the pending press; after release with btnU held high, a full DEBOUNCE_MS window SHALL elapse before a press is accepted.

Verification (TICK_DIV=4, DEBOUNCE_MS=3, NUM_SEL=7)
REQ-024 The bench SHALL cover a clean press: btnU high 20 cycles from reset -> one press_pulse between cycle 11 and 15, sel 0->1, btn_level=1.
REQ-025 The bench SHALL cover a bounce: btnU high 6 cycles, low 2, high 20 -> exactly one press_pulse, sel=1, and no pulse during the first 6-cycle burst.
REQ-026 The bench SHALL cover wrap: 7 clean presses, each with full release -> sel sequence 1,2,3,4,5,6,0 and 7 pulses.
REQ-027 The bench SHALL cover hold and release bounce: btnU high 100 cycles, then low 3/high 3/low 30 -> single pulse, btn_level returns to 0 only after the final low stretch.
REQ-028 The bench SHALL cover clear vs press: clear asserted on the press_pulse cycle with sel=4 -> sel=0 next cycle, pulse observed.
REQ-029 The bench SHALL cover reset mid-debounce: reset pulsed at cycle 8 of a press -> sel=0, no pulse; a press started after reset completes normally.

Source files
------------

// File: rtl/shape_select_ctrl.sv
// shape_select_ctrl: debounces the btnU push-button and steps a wrapping
// selection index once per accepted press. It also provides a one-cycle press
// strobe and the debounced button level.
module shape_select_ctrl #(
    parameter int TICK_DIV    = 100000,  // clk cycles per 1 ms debounce tick
    parameter int DEBOUNCE_MS = 200,     // stable ticks needed, 1..1023
    parameter int NUM_SEL     = 7        // selection values 0..NUM_SEL-1, 2..8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnU,
    input  logic       clear,
    output logic [2:0] sel,
    output logic       press_pulse,
    output logic       btn_level
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [9:0]    DEB_TICKS  = 10'(DEBOUNCE_MS);
    localparam logic [2:0]    SEL_LAST   = 3'(NUM_SEL - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    // Synchronizer, prescaler, FSM and selection state
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [PW-1:0] presc_q, presc_d;
    state_t        state_q, state_d;
    logic [9:0]    ms_cnt_q, ms_cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          press_pulse_q, press_pulse_d;

    logic       btn_s;
    logic       tick;
    logic [9:0] ms_cnt_inc;
    logic       window_done;
    logic       accept;

    assign btn_s = sync2_q;
    assign tick  = (presc_q == PRESC_LAST);

    // Synchronizer and prescaler next-state logic
    always_comb begin
        sync1_d = btnU;
        sync2_d = sync1_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Debounce FSM next-state logic; accept marks the PRESS_WAIT->HELD step
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        state_d     = state_q;
        ms_cnt_d    = ms_cnt_q;
        accept      = 1'b0;
        ms_cnt_inc  = ms_cnt_q + 10'd1;
        window_done = tick && (ms_cnt_inc == DEB_TICKS);
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = PRESS_WAIT;
                    ms_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    // Any glitch throws away the partially counted window
                    state_d  = IDLE;
                    ms_cnt_d = '0;
                end else if (window_done) begin
                    state_d  = HELD;
                    ms_cnt_d = '0;
                    accept   = 1'b1;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_inc;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d  = REL_WAIT;
                    ms_cnt_d = '0;
                end
            end
            REL_WAIT: begin
                if (btn_s) begin
                    // Release bounce: back to HELD without a new press
                    state_d  = HELD;
                    ms_cnt_d = '0;
                end else if (window_done) begin
                    state_d  = IDLE;
                    ms_cnt_d = '0;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_inc;
                end
            end
            default: begin
                state_d  = IDLE;
                ms_cnt_d = '0;
            end
        endcase
    end

    // Selection advance with wrap; clear overrides a simultaneous advance
    always_comb begin
        sel_d         = sel_q;
        press_pulse_d = accept;
        if (accept) begin
            sel_d = (sel_q >= SEL_LAST) ? 3'd0 : sel_q + 3'd1;
        end
        if (clear) begin
            sel_d = 3'd0;
        end
    end

    // State registers, all cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values of its inputs.
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            presc_q       <= '0;
            state_q       <= IDLE;
            ms_cnt_q      <= '0;
            sel_q         <= 3'd0;
            press_pulse_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            presc_q       <= presc_d;
            state_q       <= state_d;
            ms_cnt_q      <= ms_cnt_d;
            sel_q         <= sel_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign sel         = sel_q;
    assign press_pulse = press_pulse_q;
    assign btn_level   = (state_q == HELD) || (state_q == REL_WAIT);

endmodule
